// File: rtl/mult_pkg.sv
// Shared definitions for the pairwise multiply engine.
//   - default geometry (pair count, operand/product base addresses)
//   - FSM state encodings (legacy-compatible 4-bit constants)
//   - debug struct exported by the top for checker binding
//   - one shift-add step used by the sequential multiplier
package mult_pkg;

  localparam int         NUM_PAIRS    = 16;
  localparam logic [7:0] OPERAND_BASE = 8'd0;
  localparam logic [7:0] PRODUCT_BASE = 8'd64;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_RD0  = 4'd1;
  localparam logic [3:0] ST_RD1  = 4'd2;
  localparam logic [3:0] ST_RD2  = 4'd3;
  localparam logic [3:0] ST_RD3  = 4'd4;
  localparam logic [3:0] ST_MUL  = 4'd5;
  localparam logic [3:0] ST_WR0  = 4'd6;
  localparam logic [3:0] ST_WR1  = 4'd7;
  localparam logic [3:0] ST_WR2  = 4'd8;
  localparam logic [3:0] ST_WR3  = 4'd9;
  localparam logic [3:0] ST_DONE = 4'd10;

  typedef struct packed {
    logic [3:0] state;
    logic [7:0] pair;
    logic [3:0] mul_cnt;
    logic       mul_busy;
  } mult_dbg_t;

  // One iteration of the right-shifting unsigned multiplier.
  // p[31:16] is the partial-sum half, p[15:0] the remaining multiplier bits.
  // The 17-bit sum keeps the carry, which shifts into bit 31.
  function automatic logic [31:0] shift_add_step(input logic [31:0] p,
                                                 input logic [15:0] m);
    logic [16:0] s;
    s = {1'b0, p[31:16]} + (p[0] ? {1'b0, m} : 17'd0);
    return {s, p[15:1]};
  endfunction

endpackage

// File: rtl/mult_engine_if.sv
// Initiator + byte-memory bundle of the multiply engine.
//   req        : start request (initiator -> engine), only looked at in IDLE
//   done       : sticky completion flag (engine -> initiator), held until reset
//   dm_addr    : byte address (engine -> memory)
//   dm_rd_data : combinational read data for dm_addr (memory -> engine)
//   dm_wr_data : write byte (engine -> memory)
//   dm_wr_en   : write strobe, memory captures on the rising edge
// Handshake: req is a level sampled at a rising edge while the engine is idle;
// there is no ready/ack, the request is accepted at that edge and completion is
// signalled only by done, which stays high until reset.
interface mult_engine_if;
  logic       req;
  logic       done;
  logic [7:0] dm_addr;
  logic [7:0] dm_rd_data;
  logic [7:0] dm_wr_data;
  logic       dm_wr_en;

  modport master (output req, dm_rd_data,
                  input  done, dm_addr, dm_wr_data, dm_wr_en);
  modport slave  (input  req, dm_rd_data,
                  output done, dm_addr, dm_wr_data, dm_wr_en);
endinterface

// File: rtl/mul16s.sv
// Sequential signed 16x16 -> 32 multiplier.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle pulse; a/b are consumed at that edge
//   a, b       : signed operands
//   busy       : high while iterations remain after the start edge
//   product    : signed result, valid once busy has dropped
// Magnitudes are multiplied with 16 shift-add steps, the first performed at
// the start edge itself so the result is ready 16 edges after start is seen.
module mul16s
  import mult_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic               busy,
  output logic [31:0]        product
);

  logic [15:0] a_abs, b_abs;
  logic [15:0] mcand;
  logic [31:0] acc;
  logic        neg;
  logic [3:0]  cnt;

  // -32768 maps to 16'h8000, which is the correct unsigned magnitude.
  assign a_abs = a[15] ? (~a + 16'd1) : a;
  assign b_abs = b[15] ? (~b + 16'd1) : b;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand <= a_abs;
      acc   <= shift_add_step({16'd0, b_abs}, a_abs);
      neg   <= a[15] ^ b[15];
      cnt   <= 4'd15;
      busy  <= 1'b1;
    end else if (busy) begin
      acc <= shift_add_step(acc, mcand);
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) busy <= 1'b0;
    end
  end

  assign product = neg ? (~acc + 32'd1) : acc;

endmodule

// File: rtl/mult_engine.sv
// Pairwise multiply engine over a byte-wide data memory.
//   clk, reset : clock, synchronous active-high reset
//   bus        : initiator/memory bundle (slave side)
//   dbg        : FSM state, pair index, multiply counter and multiplier busy
// For each pair k: read 4 operand bytes, multiply for 16 cycles, write the
// 32-bit product big-endian at PRODUCT_BASE+4k. 24 cycles per pair; done is
// registered from the DONE state, so it rises one cycle after the last write.
module mult_engine
  import mult_pkg::*;
#(
  parameter int         NUM_PAIRS    = mult_pkg::NUM_PAIRS,
  parameter logic [7:0] PRODUCT_BASE = mult_pkg::PRODUCT_BASE
) (
  input  logic         clk,
  input  logic         reset,
  mult_engine_if.slave bus,
  output mult_dbg_t    dbg
);

  logic [3:0]         state;
  logic [7:0]         pair;
  logic [3:0]         mul_cnt;
  logic signed [15:0] op_a;   // op[2k]
  logic signed [15:0] op_b;   // op[2k+1]
  logic               done_q;
  logic               mul_busy;
  logic               mul_start;
  logic [31:0]        product;
  logic [7:0]         pair_off;

  assign pair_off  = pair << 2;
  assign mul_start = (state == ST_MUL) && (mul_cnt == 4'd0);

  mul16s u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pair    <= '0;
      mul_cnt <= '0;
      op_a    <= '0;
      op_b    <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.req) begin
          state <= ST_RD0;
          pair  <= '0;
        end
        ST_RD0: begin op_a[15:8] <= bus.dm_rd_data; state <= ST_RD1; end
        ST_RD1: begin op_a[7:0]  <= bus.dm_rd_data; state <= ST_RD2; end
        ST_RD2: begin op_b[15:8] <= bus.dm_rd_data; state <= ST_RD3; end
        ST_RD3: begin
          op_b[7:0] <= bus.dm_rd_data;
          mul_cnt   <= '0;
          state     <= ST_MUL;
        end
        // Fixed 16-cycle window matching the multiplier's 16 iterations.
        ST_MUL: begin
          mul_cnt <= mul_cnt + 4'd1;
          if (mul_cnt == 4'd15) state <= ST_WR0;
        end
        ST_WR0: state <= ST_WR1;
        ST_WR1: state <= ST_WR2;
        ST_WR2: state <= ST_WR3;
        ST_WR3: begin
          if (pair == 8'(NUM_PAIRS - 1)) begin
            state <= ST_DONE;
          end else begin
            pair  <= pair + 8'd1;
            state <= ST_RD0;
          end
        end
        ST_DONE: done_q <= 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.dm_addr    = '0;
    bus.dm_wr_data = '0;
    bus.dm_wr_en   = 1'b0;
    case (state)
      ST_RD0: bus.dm_addr = OPERAND_BASE + pair_off;
      ST_RD1: bus.dm_addr = OPERAND_BASE + pair_off + 8'd1;
      ST_RD2: bus.dm_addr = OPERAND_BASE + pair_off + 8'd2;
      ST_RD3: bus.dm_addr = OPERAND_BASE + pair_off + 8'd3;
      ST_WR0: begin
        bus.dm_addr    = PRODUCT_BASE + pair_off;
        bus.dm_wr_data = product[31:24];
        bus.dm_wr_en   = 1'b1;
      end
      ST_WR1: begin
        bus.dm_addr    = PRODUCT_BASE + pair_off + 8'd1;
        bus.dm_wr_data = product[23:16];
        bus.dm_wr_en   = 1'b1;
      end
      ST_WR2: begin
        bus.dm_addr    = PRODUCT_BASE + pair_off + 8'd2;
        bus.dm_wr_data = product[15:8];
        bus.dm_wr_en   = 1'b1;
      end
      ST_WR3: begin
        bus.dm_addr    = PRODUCT_BASE + pair_off + 8'd3;
        bus.dm_wr_data = product[7:0];
        bus.dm_wr_en   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.done = done_q;
  assign dbg      = '{state: state, pair: pair, mul_cnt: mul_cnt, mul_busy: mul_busy};

endmodule

// File: tb/tb_mult_engine.sv
module tb_mult_engine;
  import mult_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_engine_if bus();
  mult_dbg_t     dbg;

  mult_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .dbg   (dbg)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem      [0:255];
  logic [7:0] init_mem [0:255];
  logic       load;
  int         wr_count = 0;

  assign bus.dm_rd_data = mem[bus.dm_addr];

  always @(posedge clk) begin
    if (load) mem <= init_mem;
    else if (bus.dm_wr_en) mem[bus.dm_addr] <= bus.dm_wr_data;
    if (bus.dm_wr_en) wr_count <= wr_count + 1;
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_prod(input int k);
    int x, y;
    x = int'($signed({init_mem[4*k], init_mem[4*k+1]}));
    y = int'($signed({init_mem[4*k+2], init_mem[4*k+3]}));
    return 32'(y * x);
  endfunction

  task automatic check_products(input string tag);
    logic [31:0] obs;
    for (int k = 0; k < 16; k++) begin
      obs = {mem[64+4*k], mem[64+4*k+1], mem[64+4*k+2], mem[64+4*k+3]};
      check($sformatf("%s_p%0d", tag, k), obs, ref_prod(k));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_operands_zero();
    for (int i = 0; i < 256; i++) init_mem[i] = (i >= 64 && i < 128) ? 8'hAA : 8'h00;
  endtask

  task automatic load_mem();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Pulses (or holds) req, returns edges from the sampling edge to done=1.
  task automatic run(input bit hold, output int lat);
    lat = -1;
    @(negedge clk); bus.req = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk); #1;
      if (!hold) bus.req = 1'b0;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  int lat;
  int wr_before;

  initial begin
    reset   = 1'b1;
    bus.req = 1'b0;
    load    = 1'b0;
    fill_operands_zero();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wr_en", 32'(bus.dm_wr_en), 32'd0);
    reset = 1'b0;

    // all-zero operands
    load_mem();
    wr_before = wr_count;
    run(1'b0, lat);
    check("zero_latency", 32'(lat), 32'd385);
    check_products("zero");
    check("zero_writes", 32'(wr_count - wr_before), 32'd64);
    check("zero_wr_en_done", 32'(bus.dm_wr_en), 32'd0);

    // 3 * -5 = -15
    pulse_reset();
    fill_operands_zero();
    init_mem[0] = 8'h00; init_mem[1] = 8'h03; init_mem[2] = 8'hFF; init_mem[3] = 8'hFB;
    load_mem();
    run(1'b0, lat);
    check("neg15_latency", 32'(lat), 32'd385);
    check("neg15_p0", {mem[64], mem[65], mem[66], mem[67]}, 32'hFFFF_FFF1);
    check_products("neg15");

    // extreme operands
    pulse_reset();
    fill_operands_zero();
    init_mem[0] = 8'h80; init_mem[1] = 8'h00; init_mem[2] = 8'h80; init_mem[3] = 8'h00;
    init_mem[4] = 8'h7F; init_mem[5] = 8'hFF; init_mem[6] = 8'h80; init_mem[7] = 8'h00;
    load_mem();
    run(1'b0, lat);
    check("ext_latency", 32'(lat), 32'd385);
    check("ext_p0", {mem[64], mem[65], mem[66], mem[67]}, 32'h4000_0000);
    check("ext_p1", {mem[68], mem[69], mem[70], mem[71]}, 32'hC000_8000);
    check("ext_p2", {mem[72], mem[73], mem[74], mem[75]}, 32'h0000_0000);

    // reset mid-operation, then restart
    pulse_reset();
    for (int i = 0; i < 64; i++) init_mem[i] = 8'((i * 37 + 11) & 255);
    for (int i = 64; i < 128; i++) init_mem[i] = 8'hAA;
    load_mem();
    @(negedge clk); bus.req = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.req = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_wr_en", 32'(bus.dm_wr_en), 32'd0);
    @(negedge clk); reset = 1'b0;
    load_mem();
    run(1'b0, lat);
    check("restart_latency", 32'(lat), 32'd385);
    check_products("restart");

    // req held through and after done
    pulse_reset();
    load_mem();
    wr_before = wr_count;
    run(1'b1, lat);
    check("hold_latency", 32'(lat), 32'd385);
    repeat (30) @(posedge clk);
    #1;
    check("hold_done", 32'(bus.done), 32'd1);
    check("hold_writes", 32'(wr_count - wr_before), 32'd64);
    check("hold_wr_en", 32'(bus.dm_wr_en), 32'd0);
    @(negedge clk); bus.req = 1'b0;

    // random operand sets, each after a reset
    for (int r = 0; r < 10; r++) begin
      pulse_reset();
      for (int i = 0; i < 64; i++) init_mem[i] = 8'($urandom_range(0, 255));
      for (int i = 64; i < 128; i++) init_mem[i] = 8'hAA;
      load_mem();
      run(1'b0, lat);
      check($sformatf("rand%0d_latency", r), 32'(lat), 32'd385);
      check_products($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_engine.md
MULT_ENGINE -- requirements
Module: mult_engine

Interface
REQ-001 Parameter NUM_PAIRS, default 16, number of operand pairs processed per request.
REQ-002 Parameter PRODUCT_BASE, default 64, byte address of the first product.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  start request from the initiator; sampled only in IDLE.
REQ-006 done  output  1  registered completion flag; high = all products written.
REQ-007 dm_addr  output  8  byte address to data memory.
REQ-008 dm_rd_data  input  8  memory read data, combinational (valid in the same cycle as dm_addr).
REQ-009 dm_wr_data  output  8  memory write data.
REQ-010 dm_wr_en  output  1  byte write strobe; memory writes dm_wr_data at dm_addr on rising edge.

Function
REQ-011 Operand i SHALL be signed 16-bit {mem[2i], mem[2i+1]} (high byte at lower address), i = 0..2*NUM_PAIRS-1.
REQ-012 Product k SHALL be op[2k+1] * op[2k], full signed 32-bit, no truncation or saturation.
REQ-013 Product k SHALL be stored big-endian at PRODUCT_BASE+4k .. PRODUCT_BASE+4k+3 (MSB first).
REQ-014 States: IDLE, RD0, RD1, RD2, RD3, MUL, WR0, WR1, WR2, WR3, DONE.
REQ-015 IDLE -> RD0 when req=1 at a rising edge; otherwise stay in IDLE.
REQ-016 RD0..RD3 SHALL read mem[4k], mem[4k+1], mem[4k+2], mem[4k+3] in that order, one byte per cycle, into operand registers.
REQ-017 MUL SHALL last exactly 16 cycles, then go to WR0.
REQ-018 WR0..WR3 SHALL each assert dm_wr_en for exactly one cycle, writing one product byte.
REQ-019 After WR3: if k < NUM_PAIRS-1, increment k and go to RD0; else go to DONE.
REQ-020 Each pair SHALL take 24 cycles; done SHALL rise 1 + 24*NUM_PAIRS cycles (385 at default) after the edge that samples req.
REQ-021 DONE SHALL hold done=1 and dm_wr_en=0 until reset; req is ignored in DONE.
REQ-022 dm_wr_en SHALL be 0 in every state except WR0..WR3; dm_addr is don't-care in IDLE and DONE.
REQ-023 Edge cases: -32768 * -32768 = 0x40000000; any operand 0 yields 0x00000000.

Reset
REQ-024 reset=1 at a rising edge SHALL force state IDLE, k=0, done=0, dm_wr_en=0, and clear operand/product registers.
REQ-025 Reset mid-operation SHALL abort immediately; bytes already written are not restored; a later req restarts from pair 0.
REQ-026 reset SHALL take priority over req at the same edge.

Structure
REQ-027 Package mult_pkg SHALL hold the state enum and the constants NUM_PAIRS, OPERAND_BASE=0, and PRODUCT_BASE.
REQ-028 Sub-module mul16s SHALL implement a sequential signed 16x16 multiplier: absolute values, 16-cycle unsigned shift-add, conditional negate, start/busy handshake.
REQ-029 mult_engine SHALL hold the FSM, the pair counter, address generation and byte serialisation; mul16s holds only the datapath.

Verification
REQ-030 All 64 operand bytes = 0, req pulse -> bytes 64..127 all 0x00; done rises exactly 385 cycles after req is sampled.
REQ-031 mem[0:1]=0x0003, mem[2:3]=0xFFFB -> mem[64..67] = FF FF FF F1 (-15).
REQ-032 Pair 0 = (-32768, -32768), pair 1 = (op2=32767, op3=-32768) -> mem[64..67] = 40 00 00 00 and mem[68..71] = C0 00 80 00.
REQ-033 reset asserted 100 cycles after req -> next cycle done=0 and dm_wr_en=0; re-issue req -> all 16 products correct, done after 385 cycles.
REQ-034 req held high through and after done -> done stays 1, no dm_wr_en pulse after WR3 of pair 15.
REQ-035 Ten back-to-back random operand sets, each separated by reset -> all 16 products match the 32-bit signed reference model every run.
